// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, addressing-mode codes and state encoding shared by the control sequencer.
package ctrl_pkg;

    localparam int CNT_W = 4;

    localparam logic [5:0] OP_NOP     = 6'b000000;
    localparam logic [5:0] OP_LOAD    = 6'b000001;
    localparam logic [5:0] OP_REGLOAD = 6'b000010;
    localparam logic [5:0] OP_POP     = 6'b000011;
    localparam logic [5:0] OP_PUSH    = 6'b000100;
    localparam logic [5:0] OP_JMP     = 6'b001000;
    localparam logic [5:0] OP_BEQL    = 6'b010000;
    localparam logic [5:0] OP_BNEQL   = 6'b010001;
    localparam logic [5:0] OP_ADD     = 6'b110000;
    localparam logic [5:0] OP_SUB     = 6'b110001;
    localparam logic [5:0] OP_INC     = 6'b110010;
    localparam logic [5:0] OP_DEC     = 6'b110011;
    localparam logic [5:0] OP_AND     = 6'b110100;
    localparam logic [5:0] OP_OR      = 6'b110101;
    localparam logic [5:0] OP_XOR     = 6'b110110;
    localparam logic [5:0] OP_NOT     = 6'b110111;
    localparam logic [5:0] OP_ASR     = 6'b111000;
    localparam logic [5:0] OP_LSR     = 6'b111001;
    localparam logic [5:0] OP_ASL     = 6'b111010;
    localparam logic [5:0] OP_LSL     = 6'b111011;

    localparam logic [2:0] FUNCT_REG   = 3'b000;
    localparam logic [2:0] FUNCT_MEM   = 3'b010;
    localparam logic [2:0] FUNCT_PCREL = 3'b110;
    localparam logic [2:0] FUNCT_IMM   = 3'b111;

    typedef enum logic [4:0] {
        INIT_SP    = 5'd0,
        FETCH      = 5'd1,
        DEC_OP     = 5'd2,
        DEC_ADDR   = 5'd3,
        ADDR_REG   = 5'd4,
        ADDR_MEM   = 5'd5,
        ADDR_PCREL = 5'd6,
        ADDR_IMM   = 5'd7,
        EXEC_LOAD  = 5'd8,
        EXEC_SHIFT = 5'd9,
        POP        = 5'd10,
        PUSH       = 5'd11,
        WRITEBACK  = 5'd12,
        PC_INC     = 5'd13,
        JUMP       = 5'd14,
        ILLEGAL    = 5'd15,
        HALT       = 5'd16,
        IRQ_SAVE   = 5'd17,
        IRQ_VEC    = 5'd18
    } state_t;

endpackage

// File: rtl/ctrl_sequencer_seq_counter.sv
// seq_counter: loadable down-counter that steps only on mem_ack and flags terminal count.
module seq_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         tc
);

    logic [W-1:0] count_q, count_d;

    always_comb count_d = load ? load_val : (dec && count_q != '0) ? count_q - W'(1) : count_q;

    always_ff @(posedge clk) count_q <= reset ? '0 : count_d;

    assign count = count_q;
    assign tc    = count_q == '0;

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: instruction fetch/decode/execute control FSM.
// Define CTRL_SEQ_IRQ_EN to add the irq/irq_ack interrupt entry path.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int FETCH_BYTES  = 4,
    parameter int PCREL_CYCLES = 5,
    parameter int OP_W         = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic [2:0]      funct,
    input  logic            zero,
    input  logic            mem_ack,
`ifdef CTRL_SEQ_IRQ_EN
    input  logic            irq,
    output logic            irq_ack,
`endif
    output logic            mem_req,
    output logic [4:0]      state,
    output logic [2:0]      byte_idx,
    output logic            pc_inc,
    output logic            instr_done,
    output logic            illegal,
    output logic            halted
);

    state_t state_q, state_d;
    logic illegal_q, illegal_d;
    logic cnt_ld, cnt_tc;
    logic [CNT_W-1:0] cnt_ld_val, cnt;
    logic acked_tc;

    assign acked_tc = mem_ack && cnt_tc;

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT_SP: state_d = FETCH;
            FETCH:   state_d = acked_tc ? DEC_OP : FETCH;
            DEC_OP: begin
                case (op)
                    OP_W'(OP_NOP), OP_W'(OP_REGLOAD): state_d = WRITEBACK;
                    OP_W'(OP_JMP):   state_d = JUMP;
                    OP_W'(OP_BEQL):  state_d = zero ? JUMP : PC_INC;
                    OP_W'(OP_BNEQL): state_d = zero ? PC_INC : JUMP;
                    OP_W'(OP_LOAD):  state_d = EXEC_LOAD;
                    OP_W'(OP_POP):   state_d = POP;
                    OP_W'(OP_PUSH):  state_d = PUSH;
                    OP_W'(OP_ADD), OP_W'(OP_SUB), OP_W'(OP_INC), OP_W'(OP_DEC),
                    OP_W'(OP_AND), OP_W'(OP_OR), OP_W'(OP_XOR), OP_W'(OP_NOT):
                        state_d = DEC_ADDR;
                    OP_W'(OP_ASR), OP_W'(OP_LSR), OP_W'(OP_ASL), OP_W'(OP_LSL):
                        state_d = EXEC_SHIFT;
                    default: state_d = (op == '1) ? HALT : ILLEGAL;
                endcase
            end
            DEC_ADDR: state_d = (funct == FUNCT_REG)   ? ADDR_REG :
                                (funct == FUNCT_MEM)   ? ADDR_MEM :
                                (funct == FUNCT_PCREL) ? ADDR_PCREL : ADDR_IMM;
            ADDR_REG, ADDR_IMM:   state_d = WRITEBACK;
            ADDR_MEM, ADDR_PCREL: state_d = acked_tc ? WRITEBACK : state_q;
            POP, PUSH:            state_d = acked_tc ? PC_INC : state_q;
            EXEC_LOAD, EXEC_SHIFT, WRITEBACK, ILLEGAL: state_d = PC_INC;
`ifdef CTRL_SEQ_IRQ_EN
            PC_INC, JUMP: state_d = irq ? IRQ_SAVE : FETCH;
            IRQ_SAVE:     state_d = acked_tc ? IRQ_VEC : IRQ_SAVE;
            IRQ_VEC:      state_d = FETCH;
`else
            PC_INC, JUMP: state_d = FETCH;
`endif
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Fetch and multi-cycle states never follow themselves, so every state change reloads the counter.
    always_comb begin
        cnt_ld     = state_d != state_q;
        cnt_ld_val = (state_d == FETCH)      ? CNT_W'(FETCH_BYTES - 1) :
                     (state_d == ADDR_PCREL) ? CNT_W'(PCREL_CYCLES - 1) : CNT_W'(1);
        illegal_d  = illegal_q || state_d == ILLEGAL;
    end

    always_ff @(posedge clk) begin
        state_q   <= reset ? INIT_SP : state_d;
        illegal_q <= reset ? 1'b0 : illegal_d;
    end

    seq_counter #(.W(CNT_W)) u_seq_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_ld),
        .load_val (cnt_ld_val),
        .dec      (mem_ack),
        .count    (cnt),
        .tc       (cnt_tc)
    );

    assign state      = state_q;
    assign byte_idx   = (state_q == FETCH) ? 3'(CNT_W'(FETCH_BYTES - 1) - cnt) : 3'd0;
    assign pc_inc     = state_q == PC_INC;
    assign instr_done = state_q inside {PC_INC, JUMP, ILLEGAL};
    assign illegal    = illegal_q;
    assign halted     = state_q == HALT;
`ifdef CTRL_SEQ_IRQ_EN
    assign mem_req    = state_q inside {FETCH, ADDR_MEM, ADDR_PCREL, POP, PUSH, IRQ_SAVE};
    assign irq_ack    = state_q == IRQ_VEC;
`else
    assign mem_req    = state_q inside {FETCH, ADDR_MEM, ADDR_PCREL, POP, PUSH};
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed cycle-by-cycle checks of the control sequencer state trace and outputs.
module tb_ctrl_sequencer;
    import ctrl_pkg::*;

    localparam logic [4:0] MR = 5'b10000;
    localparam logic [4:0] PI = 5'b01000;
    localparam logic [4:0] ID = 5'b00100;
    localparam logic [4:0] IL = 5'b00010;
    localparam logic [4:0] HL = 5'b00001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = OP_NOP;
    logic [2:0] funct = 3'b000;
    logic       zero = 1'b0;
    logic       mem_ack = 1'b1;
    logic       mem_req, pc_inc, instr_done, illegal, halted;
    logic [4:0] state;
    logic [2:0] byte_idx;
    logic [4:0] outs;
`ifdef CTRL_SEQ_IRQ_EN
    logic       irq = 1'b0;
    logic       irq_ack;
`endif
    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    ctrl_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ack    (mem_ack),
`ifdef CTRL_SEQ_IRQ_EN
        .irq        (irq),
        .irq_ack    (irq_ack),
`endif
        .mem_req    (mem_req),
        .state      (state),
        .byte_idx   (byte_idx),
        .pc_inc     (pc_inc),
        .instr_done (instr_done),
        .illegal    (illegal),
        .halted     (halted)
    );

    assign outs = {mem_req, pc_inc, instr_done, illegal, halted};

    task automatic chk_step(input string tag, input state_t es, input logic [2:0] eb, input logic [4:0] eo);
        @(posedge clk);
        #1;
        vecs++;
        assert ({state, byte_idx, outs} === {es, eb, eo}) else begin
            errs++;
            $error("FAIL %s: observed state=%0d idx=%0d outs=%b, expected state=%0d idx=%0d outs=%b",
                   tag, state, byte_idx, outs, es, eb, eo);
        end
    endtask

    task automatic fetch(input string tag, input logic [4:0] fl);
        for (int i = 0; i < 4; i++) chk_step(tag, FETCH, 3'(i), MR | fl);
    endtask

    initial begin
        op = OP_ADD;
        chk_step("reset0", INIT_SP, 3'd0, 5'b0);
        chk_step("reset1", INIT_SP, 3'd0, 5'b0);
        reset = 1'b0;
        fetch("add_fetch", 5'b0);
        chk_step("add_decop", DEC_OP, 3'd0, 5'b0);
        chk_step("add_decaddr", DEC_ADDR, 3'd0, 5'b0);
        chk_step("add_reg", ADDR_REG, 3'd0, 5'b0);
        chk_step("add_wb", WRITEBACK, 3'd0, 5'b0);
        chk_step("add_pcinc", PC_INC, 3'd0, PI | ID);

        op = OP_BEQL;
        zero = 1'b0;
        fetch("beql0_fetch", 5'b0);
        chk_step("beql0_decop", DEC_OP, 3'd0, 5'b0);
        chk_step("beql0_pcinc", PC_INC, 3'd0, PI | ID);
        zero = 1'b1;
        fetch("beql1_fetch", 5'b0);
        chk_step("beql1_decop", DEC_OP, 3'd0, 5'b0);
        chk_step("beql1_jump", JUMP, 3'd0, ID);

        op = OP_NOP;
        zero = 1'b0;
        chk_step("stall_b0", FETCH, 3'd0, MR);
        chk_step("stall_b1", FETCH, 3'd1, MR);
        chk_step("stall_b2", FETCH, 3'd2, MR);
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) chk_step("stall_hold", FETCH, 3'd2, MR);
        mem_ack = 1'b1;
        chk_step("stall_b3", FETCH, 3'd3, MR);
        chk_step("stall_decop", DEC_OP, 3'd0, 5'b0);
        chk_step("nop_wb", WRITEBACK, 3'd0, 5'b0);
        chk_step("nop_pcinc", PC_INC, 3'd0, PI | ID);

        op = OP_ADD;
        funct = 3'b110;
        fetch("pcrel_fetch", 5'b0);
        chk_step("pcrel_decop", DEC_OP, 3'd0, 5'b0);
        chk_step("pcrel_decaddr", DEC_ADDR, 3'd0, 5'b0);
        chk_step("pcrel_c1", ADDR_PCREL, 3'd0, MR);
        mem_ack = 1'b0;
        chk_step("pcrel_hold", ADDR_PCREL, 3'd0, MR);
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) chk_step("pcrel_cn", ADDR_PCREL, 3'd0, MR);
        chk_step("pcrel_wb", WRITEBACK, 3'd0, 5'b0);
        chk_step("pcrel_pcinc", PC_INC, 3'd0, PI | ID);

        op = OP_SUB;
        funct = 3'b010;
        fetch("mem_fetch", 5'b0);
        chk_step("mem_decop", DEC_OP, 3'd0, 5'b0);
        chk_step("mem_decaddr", DEC_ADDR, 3'd0, 5'b0);
        chk_step("mem_c1", ADDR_MEM, 3'd0, MR);
        chk_step("mem_c2", ADDR_MEM, 3'd0, MR);
        chk_step("mem_wb", WRITEBACK, 3'd0, 5'b0);
        chk_step("mem_pcinc", PC_INC, 3'd0, PI | ID);

        op = OP_XOR;
        funct = 3'b011;
        fetch("imm_fetch", 5'b0);
        chk_step("imm_decop", DEC_OP, 3'd0, 5'b0);
        chk_step("imm_decaddr", DEC_ADDR, 3'd0, 5'b0);
        chk_step("imm_imm", ADDR_IMM, 3'd0, 5'b0);
        chk_step("imm_wb", WRITEBACK, 3'd0, 5'b0);
        chk_step("imm_pcinc", PC_INC, 3'd0, PI | ID);

        op = OP_POP;
        fetch("pop_fetch", 5'b0);
        chk_step("pop_decop", DEC_OP, 3'd0, 5'b0);
        chk_step("pop_c1", POP, 3'd0, MR);
        chk_step("pop_c2", POP, 3'd0, MR);
        chk_step("pop_pcinc", PC_INC, 3'd0, PI | ID);

        op = OP_LOAD;
        fetch("load_fetch", 5'b0);
        chk_step("load_decop", DEC_OP, 3'd0, 5'b0);
        chk_step("load_exec", EXEC_LOAD, 3'd0, 5'b0);
        chk_step("load_pcinc", PC_INC, 3'd0, PI | ID);

        op = OP_LSL;
        fetch("lsl_fetch", 5'b0);
        chk_step("lsl_decop", DEC_OP, 3'd0, 5'b0);
        chk_step("lsl_exec", EXEC_SHIFT, 3'd0, 5'b0);
        chk_step("lsl_pcinc", PC_INC, 3'd0, PI | ID);

        op = OP_BNEQL;
        fetch("bneql_fetch", 5'b0);
        chk_step("bneql_decop", DEC_OP, 3'd0, 5'b0);
        chk_step("bneql_jump", JUMP, 3'd0, ID);

        op = 6'b010101;
        fetch("ill_fetch", 5'b0);
        chk_step("ill_decop", DEC_OP, 3'd0, 5'b0);
        chk_step("ill_state", ILLEGAL, 3'd0, ID | IL);
        chk_step("ill_pcinc", PC_INC, 3'd0, PI | ID | IL);
        op = OP_NOP;
        for (int i = 0; i < 3; i++) begin
            fetch("ill_sticky_fetch", IL);
            chk_step("ill_sticky_decop", DEC_OP, 3'd0, IL);
            chk_step("ill_sticky_wb", WRITEBACK, 3'd0, IL);
            chk_step("ill_sticky_pcinc", PC_INC, 3'd0, PI | ID | IL);
        end
        reset = 1'b1;
        chk_step("ill_clear", INIT_SP, 3'd0, 5'b0);
        reset = 1'b0;

        op = OP_ADD;
        funct = 3'b110;
        fetch("abort_fetch", 5'b0);
        chk_step("abort_decop", DEC_OP, 3'd0, 5'b0);
        chk_step("abort_decaddr", DEC_ADDR, 3'd0, 5'b0);
        for (int i = 0; i < 3; i++) chk_step("abort_pcrel", ADDR_PCREL, 3'd0, MR);
        reset = 1'b1;
        chk_step("abort_reset", INIT_SP, 3'd0, 5'b0);
        reset = 1'b0;
        op = OP_NOP;
        fetch("abort_refetch", 5'b0);
        chk_step("abort_decop2", DEC_OP, 3'd0, 5'b0);
        chk_step("abort_wb", WRITEBACK, 3'd0, 5'b0);
        chk_step("abort_pcinc", PC_INC, 3'd0, PI | ID);

`ifdef CTRL_SEQ_IRQ_EN
        fetch("irq_fetch", 5'b0);
        chk_step("irq_decop", DEC_OP, 3'd0, 5'b0);
        chk_step("irq_wb", WRITEBACK, 3'd0, 5'b0);
        irq = 1'b1;
        chk_step("irq_pcinc", PC_INC, 3'd0, PI | ID);
        irq = 1'b0;
        chk_step("irq_save1", IRQ_SAVE, 3'd0, MR);
        chk_step("irq_save2", IRQ_SAVE, 3'd0, MR);
        chk_step("irq_vec", IRQ_VEC, 3'd0, 5'b0);
        vecs++;
        assert (irq_ack === 1'b1) else begin
            errs++;
            $error("FAIL irq_ack: observed %b expected 1", irq_ack);
        end
`endif

        op = 6'b111111;
        fetch("halt_fetch", 5'b0);
        chk_step("halt_decop", DEC_OP, 3'd0, 5'b0);
        chk_step("halt_enter", HALT, 3'd0, HL);
`ifdef CTRL_SEQ_IRQ_EN
        irq = 1'b1;
`endif
        mem_ack = 1'b0;
        chk_step("halt_hold0", HALT, 3'd0, HL);
        mem_ack = 1'b1;
        chk_step("halt_hold1", HALT, 3'd0, HL);
        reset = 1'b1;
        chk_step("halt_reset", INIT_SP, 3'd0, 5'b0);
        reset = 1'b0;
        chk_step("halt_restart", FETCH, 3'd0, MR);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
